// File: rtl/npc_core_mc.sv
// npc_core_mc: multi-cycle RV32I/RV64I integer core.
// Each instruction takes FETCH -> WAIT -> EXEC, so it needs at least three cycles.
// The core supports lui, auipc, jal, jalr, addi, slti, sltiu, xori, ori, andi, add, sub
// and ebreak. Any other encoding, or a jump target with bit 1 set, halts the core as illegal.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   ifu_req_valid/_ready, ifu_addr   fetch request handshake; ifu_addr is the pc
//   ifu_rsp_valid, ifu_inst          instruction response; sampled only in WAIT
//   pc                 current pc
//   commit_valid       one-cycle pulse per retired instruction
//   rf_wen/_waddr/_wdata  register write trace; these are zero unless commit_valid is set
//   halted, illegal    sticky halt status
//   halt_code          a0 (x10) captured at ebreak; 0 on an illegal halt
module npc_core_mc #(
    parameter int          XLEN     = 64,
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [31:0]     ifu_addr,
    input  logic            ifu_rsp_valid,
    input  logic [31:0]     ifu_inst,
    output logic [31:0]     pc,
    output logic            commit_valid,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            halted,
    output logic            illegal,
    output logic [XLEN-1:0] halt_code
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state, state_nxt;
    logic            started;
    logic [31:0]     pc_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] regs [32];
    logic            halted_q, illegal_q;
    logic [XLEN-1:0] halt_code_q;

    // Decode fields
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_u, pc_x, rs1_val, rs2_val;
    logic [31:0]     imm_j;

    // Execute results
    logic            dec_valid, dec_wr, dec_jump, dec_ebreak;
    logic [XLEN-1:0] result;
    logic [31:0]     target;
    logic            bad;
    logic            exec_commit;

    assign opcode  = inst_q[6:0];
    assign rd      = inst_q[11:7];
    assign funct3  = inst_q[14:12];
    assign rs1     = inst_q[19:15];
    assign rs2     = inst_q[24:20];
    assign funct7  = inst_q[31:25];
    assign imm_i   = XLEN'($signed(inst_q[31:20]));
    assign imm_u   = XLEN'($signed({inst_q[31:12], 12'h000}));
    assign imm_j   = 32'($signed({inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0}));
    assign pc_x    = XLEN'(pc_q);
    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

    // Instruction decode and ALU
    always_comb begin
        dec_valid  = 1'b0;
        dec_wr     = 1'b0;
        dec_jump   = 1'b0;
        dec_ebreak = 1'b0;
        result     = '0;
        target     = '0;
        case (opcode)
            7'b0110111: begin                       // lui
                dec_valid = 1'b1;
                dec_wr    = 1'b1;
                result    = imm_u;
            end
            7'b0010111: begin                       // auipc
                dec_valid = 1'b1;
                dec_wr    = 1'b1;
                result    = pc_x + imm_u;
            end
            7'b1101111: begin                       // jal
                dec_valid = 1'b1;
                dec_wr    = 1'b1;
                dec_jump  = 1'b1;
                result    = XLEN'(pc_q + 32'd4);
                target    = pc_q + imm_j;
            end
            7'b1100111: begin                       // jalr
                if (funct3 == 3'b000) begin
                    dec_valid = 1'b1;
                    dec_wr    = 1'b1;
                    dec_jump  = 1'b1;
                    result    = XLEN'(pc_q + 32'd4);
                    // Only the low 32 bits of the sum reach pc, so the sum is taken at 32 bits.
                    target    = (rs1_val[31:0] + imm_i[31:0]) & ~32'd1;
                end
            end
            7'b0010011: begin                       // OP-IMM
                dec_wr = 1'b1;
                case (funct3)
                    3'b000: begin dec_valid = 1'b1; result = rs1_val + imm_i; end
                    3'b010: begin dec_valid = 1'b1; result = XLEN'($signed(rs1_val) < $signed(imm_i)); end
                    3'b011: begin dec_valid = 1'b1; result = XLEN'(rs1_val < imm_i); end
                    3'b100: begin dec_valid = 1'b1; result = rs1_val ^ imm_i; end
                    3'b110: begin dec_valid = 1'b1; result = rs1_val | imm_i; end
                    3'b111: begin dec_valid = 1'b1; result = rs1_val & imm_i; end
                    default: dec_valid = 1'b0;
                endcase
            end
            7'b0110011: begin                       // OP: add/sub only
                dec_wr = 1'b1;
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec_valid = 1'b1;
                    result    = rs1_val + rs2_val;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec_valid = 1'b1;
                    result    = rs1_val - rs2_val;
                end
            end
            7'b1110011: begin
                if (inst_q == 32'h00100073) begin
                    dec_valid  = 1'b1;
                    dec_ebreak = 1'b1;
                end
            end
            default: dec_valid = 1'b0;
        endcase
    end

    assign bad = !dec_valid || (dec_jump && target[1]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (ifu_req_valid && ifu_req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (ifu_rsp_valid) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = (bad || dec_ebreak) ? S_HALT : S_FETCH;
            default: state_nxt = S_HALT;
        endcase
    end

    // Datapath state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            halt_code_q <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // Holds the first request back by one cycle, so ifu_req_valid stays low
            // throughout reset.
            started <= 1'b1;
            if (state == S_WAIT && ifu_rsp_valid) begin
                inst_q <= ifu_inst;
            end
            if (state == S_EXEC) begin
                if (bad) begin
                    illegal_q   <= 1'b1;
                    halted_q    <= 1'b1;
                    halt_code_q <= '0;
                end else if (dec_ebreak) begin
                    halted_q    <= 1'b1;
                    halt_code_q <= regs[10];
                end else begin
                    pc_q <= dec_jump ? target : pc_q + 32'd4;
                    if (dec_wr && rd != 5'd0) begin
                        regs[rd] <= result;
                    end
                end
            end
        end
    end

    // Outputs
    always_comb begin
        exec_commit   = (state == S_EXEC) && !bad;
        ifu_req_valid = (state == S_FETCH) && started;
        commit_valid  = exec_commit;
        rf_wen        = exec_commit && dec_wr && (rd != 5'd0);
        rf_waddr      = (exec_commit && dec_wr) ? rd : 5'd0;
        rf_wdata      = (exec_commit && dec_wr) ? result : '0;
    end

    assign ifu_addr  = pc_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign halt_code = halt_code_q;

endmodule

// File: tb/tb_npc_core_mc.sv
// Directed testbench for npc_core_mc (XLEN=64).
// A small instruction memory answers combinationally from ifu_addr.
module tb_npc_core_mc;

    localparam logic [31:0] RPC    = 32'h80000000;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_inst, pc;
    logic        commit_valid, rf_wen, halted, illegal;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata, halt_code;
    logic [31:0] mem [16];

    int checks = 0;
    int errors = 0;

    npc_core_mc #(.XLEN(64), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_inst(ifu_inst), .pc(pc),
        .commit_valid(commit_valid), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .halted(halted), .illegal(illegal), .halt_code(halt_code)
    );

    always #5 clk = ~clk;
    assign ifu_inst = mem[ifu_addr[5:2]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Holds reset for two cycles with the memory preloaded, then releases it on a falling edge.
    task automatic start(input logic ready, input logic rsp);
        rst_n = 1'b0;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        ifu_req_ready = ready;
        ifu_rsp_valid = rsp;
        rst_n = 1'b1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = EBREAK;
    endtask

    task automatic wait_commit(output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (commit_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        fill_mem();
        rst_n = 1'b0;
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ifu_req_valid, commit_valid, rf_wen, halted, illegal} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {ifu_req_valid, commit_valid, rf_wen, halted, illegal});
        end
        checks++;
        if (ifu_addr !== RPC || pc !== RPC) begin
            errors++;
            $display("FAIL reset_pc: got addr %h pc %h expected %h", ifu_addr, pc, RPC);
        end
        checks++;
        if (halt_code !== 64'd0 || rf_wdata !== 64'd0 || rf_waddr !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: got code %h wdata %h waddr %0d expected 0", halt_code, rf_wdata, rf_waddr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ifu_req_valid !== 1'b1 || ifu_addr !== RPC) begin
            errors++;
            $display("FAIL reset_first_req: got valid %b addr %h expected 1 %h", ifu_req_valid, ifu_addr, RPC);
        end
    endtask

    task automatic test_addi();
        bit ok;
        int cyc;
        fill_mem();
        mem[0] = 32'h00500093;   // addi x1,x0,5
        mem[1] = 32'hFFF08113;   // addi x2,x1,-1
        start(1'b1, 1'b1);
        wait_commit(ok, cyc);
        checks++;
        if (!ok || cyc != 3 || {rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 64'd5}) begin
            errors++;
            $display("FAIL addi_x1: got ok %0d cyc %0d wen %b waddr %0d wdata %h expected 1 3 1 1 5",
                     ok, cyc, rf_wen, rf_waddr, rf_wdata);
        end
        wait_commit(ok, cyc);
        checks++;
        if (!ok || cyc != 3 || {rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 64'd4}) begin
            errors++;
            $display("FAIL addi_x2: got ok %0d cyc %0d wen %b waddr %0d wdata %h expected 1 3 1 2 4",
                     ok, cyc, rf_wen, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        checks++;
        if (pc !== 32'h80000008) begin
            errors++;
            $display("FAIL addi_pc: got %h expected 80000008", pc);
        end
        checks++;
        if ({commit_valid, rf_wen, rf_waddr, rf_wdata} !== 71'd0) begin
            errors++;
            $display("FAIL trace_idle: got commit %b wen %b waddr %0d wdata %h expected all 0",
                     commit_valid, rf_wen, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int cyc;
        fill_mem();
        mem[0] = 32'h00500093;
        start(1'b0, 1'b1);           // stray rsp_valid held high throughout FETCH
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ifu_req_valid !== 1'b1 || ifu_addr !== RPC || commit_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid %b addr %h commit %b expected 1 %h 0",
                         i, ifu_req_valid, ifu_addr, commit_valid, RPC);
            end
        end
        ifu_req_ready = 1'b1;
        wait_commit(ok, cyc);
        checks++;
        if (!ok || cyc != 2 || rf_wdata !== 64'd5) begin
            errors++;
            $display("FAIL stall_release: got ok %0d cyc %0d wdata %h expected 1 2 5", ok, cyc, rf_wdata);
        end
    endtask

    task automatic test_jump();
        bit ok;
        int cyc;
        int commits;
        fill_mem();
        mem[0] = 32'h008000EF;   // jal x1,8
        mem[2] = 32'h002081E7;   // jalr x3,2(x1): target 0x80000006
        start(1'b1, 1'b1);
        wait_commit(ok, cyc);
        checks++;
        if (!ok || {rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 64'h0000_0000_8000_0004}) begin
            errors++;
            $display("FAIL jal_link: got ok %0d wen %b waddr %0d wdata %h expected 1 1 1 80000004",
                     ok, rf_wen, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        checks++;
        if (ifu_req_valid !== 1'b1 || ifu_addr !== 32'h80000008) begin
            errors++;
            $display("FAIL jal_target: got valid %b addr %h expected 1 80000008", ifu_req_valid, ifu_addr);
        end
        commits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (commit_valid) commits++;
        end
        checks++;
        if (commits != 0) begin
            errors++;
            $display("FAIL jalr_no_commit: got %0d commits expected 0", commits);
        end
        checks++;
        if ({illegal, halted, ifu_req_valid} !== 3'b110 || halt_code !== 64'd0 || pc !== 32'h80000008) begin
            errors++;
            $display("FAIL jalr_misaligned: got ill %b halt %b req %b code %h pc %h expected 1 1 0 0 80000008",
                     illegal, halted, ifu_req_valid, halt_code, pc);
        end
    endtask

    task automatic test_ebreak();
        bit ok;
        int cyc;
        int busy;
        fill_mem();
        mem[0] = 32'h00700513;   // addi x10,x0,7
        start(1'b1, 1'b1);
        wait_commit(ok, cyc);
        checks++;
        if (!ok || {rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 64'd7}) begin
            errors++;
            $display("FAIL ebreak_a0: got ok %0d wen %b waddr %0d wdata %h expected 1 1 10 7",
                     ok, rf_wen, rf_waddr, rf_wdata);
        end
        wait_commit(ok, cyc);
        checks++;
        if (!ok || cyc != 3 || rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_commit: got ok %0d cyc %0d wen %b expected 1 3 0", ok, cyc, rf_wen);
        end
        @(negedge clk);
        checks++;
        if ({halted, illegal} !== 2'b10 || halt_code !== 64'd7 || pc !== 32'h80000004) begin
            errors++;
            $display("FAIL ebreak_halt: got halt %b ill %b code %h pc %h expected 1 0 7 80000004",
                     halted, illegal, halt_code, pc);
        end
        busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifu_req_valid || commit_valid) busy++;
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL ebreak_quiet: got %0d active cycles expected 0", busy);
        end
    endtask

    task automatic test_alu();
        bit ok;
        int cyc;
        logic [31:0] prog [9];
        logic [4:0]  ewa  [9];
        logic [63:0] ewd  [9];
        logic        ewe  [9];
        prog = '{32'hFFFFF2B7, 32'hFFF03313, 32'h0002A393, 32'h40500433, 32'hFFF2C493,
                 32'h00001597, 32'h00500013, 32'h0F04F613, 32'h00F46693};
        ewa  = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd11, 5'd0, 5'd12, 5'd13};
        ewd  = '{64'hFFFF_FFFF_FFFF_F000, 64'd1, 64'd1, 64'h1000, 64'h0FFF,
                 64'h0000_0000_8000_1014, 64'd5, 64'h00F0, 64'h100F};
        ewe  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        fill_mem();
        for (int i = 0; i < 9; i++) mem[i] = prog[i];
        start(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            wait_commit(ok, cyc);
            checks++;
            if (!ok || {rf_wen, rf_waddr, rf_wdata} !== {ewe[i], ewa[i], ewd[i]}) begin
                errors++;
                $display("FAIL alu[%0d]: got ok %0d wen %b waddr %0d wdata %h expected %b %0d %h",
                         i, ok, rf_wen, rf_waddr, rf_wdata, ewe[i], ewa[i], ewd[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int commits;
        fill_mem();
        mem[0] = 32'hFFFFFFFF;
        start(1'b1, 1'b1);
        commits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (commit_valid) commits++;
        end
        checks++;
        if (commits != 0 || {illegal, halted, ifu_req_valid} !== 3'b110 || halt_code !== 64'd0) begin
            errors++;
            $display("FAIL illegal_inst: got commits %0d ill %b halt %b req %b code %h expected 0 1 1 0 0",
                     commits, illegal, halted, ifu_req_valid, halt_code);
        end
    endtask

    task automatic test_reset_wait();
        bit ok;
        int cyc;
        fill_mem();
        mem[0] = 32'h00500093;   // addi x1,x0,5
        start(1'b1, 1'b1);
        wait_commit(ok, cyc);
        ifu_rsp_valid = 1'b0;
        @(negedge clk);          // FETCH of 0x80000004
        @(negedge clk);          // now waiting for the response
        checks++;
        if (ifu_req_valid !== 1'b0 || ifu_addr !== 32'h80000004) begin
            errors++;
            $display("FAIL wait_state: got valid %b addr %h expected 0 80000004", ifu_req_valid, ifu_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ifu_req_valid !== 1'b0 || ifu_addr !== RPC || pc !== RPC) begin
            errors++;
            $display("FAIL reset_in_wait: got valid %b addr %h pc %h expected 0 %h", ifu_req_valid, ifu_addr, pc, RPC);
        end
        mem[0] = 32'h002081B3;   // add x3,x1,x2
        @(negedge clk);
        rst_n = 1'b1;
        ifu_rsp_valid = 1'b1;
        wait_commit(ok, cyc);
        checks++;
        if (!ok || cyc != 3 || {rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 64'd0}) begin
            errors++;
            $display("FAIL regs_cleared: got ok %0d cyc %0d wen %b waddr %0d wdata %h expected 1 3 1 3 0",
                     ok, cyc, rf_wen, rf_waddr, rf_wdata);
        end
    endtask

    initial begin
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        #1;
        test_reset();
        test_addi();
        test_stall();
        test_jump();
        test_ebreak();
        test_alu();
        test_illegal();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
